// File: rtl/rng_byte_reader.sv
// Consumer side of the ring-oscillator RNG: samples d_in, XOR-folds it to a raw bit,
// applies von Neumann debiasing, packs bytes into a FWFT FIFO and runs a repetition health test.
module rng_byte_reader #(
  parameter int SAMPLE_DIV = 4,
  parameter int DEPTH      = 4,
  parameter int REP_LIMIT  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [7:0]                 d_in,
  output logic [7:0]                 rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       overflow,
  output logic                       health_fail
);
  localparam int AW    = $clog2(DEPTH);
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  logic [DIV_W-1:0]          div_cnt;
  logic                      tick;
  logic                      smp_vld, smp_bit;
  logic                      proc;
  logic                      vn_held, vn_first;
  logic                      emit;
  logic [7:0]                sr, sr_next;
  logic [2:0]                bit_cnt;
  logic                      have_prev, prev_bit;
  logic [REP_W-1:0]          rep_cnt, rep_next;
  logic                      fail_now;
  logic                      push_req, push_ok, pop, full;
  logic [DEPTH-1:0][7:0]     mem;
  logic [AW-1:0]             wptr, rptr;

  assign tick = en && (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_comb begin
    proc     = smp_vld & en;
    rep_next = rep_cnt;
    if (!have_prev || (smp_bit != prev_bit))
      rep_next = REP_W'(1);
    else if (rep_cnt != REP_W'(REP_LIMIT))
      rep_next = rep_cnt + REP_W'(1);
    // A pair "10" emits 1 and "01" emits 0, i.e. the first bit of a differing pair.
    emit     = proc & vn_held & (vn_first != smp_bit);
    sr_next  = {sr[6:0], vn_first};
    push_req = emit && (bit_cnt == 3'd7);
    fail_now = proc && !health_fail && (rep_next == REP_W'(REP_LIMIT));
    full     = (fill == (AW+1)'(DEPTH));
    rd_valid = (fill != '0) && !health_fail;
    pop      = rd_valid & rd_ready;
    push_ok  = push_req && !health_fail && !fail_now && (!full || pop);
  end

  // Sampling, debias, packing and repetition state; all cleared while en=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      smp_vld   <= 1'b0;
      smp_bit   <= 1'b0;
      vn_held   <= 1'b0;
      vn_first  <= 1'b0;
      sr        <= '0;
      bit_cnt   <= '0;
      have_prev <= 1'b0;
      prev_bit  <= 1'b0;
      rep_cnt   <= '0;
    end else if (!en) begin
      div_cnt   <= '0;
      smp_vld   <= 1'b0;
      vn_held   <= 1'b0;
      sr        <= '0;
      bit_cnt   <= '0;
      have_prev <= 1'b0;
      rep_cnt   <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      smp_vld <= tick;
      if (tick) smp_bit <= ^d_in;
      if (proc) begin
        have_prev <= 1'b1;
        prev_bit  <= smp_bit;
        rep_cnt   <= rep_next;
        vn_held   <= !vn_held;
        if (!vn_held) vn_first <= smp_bit;
      end
      if (emit) begin
        sr      <= sr_next;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem         <= '0;
      wptr        <= '0;
      rptr        <= '0;
      fill        <= '0;
      overflow    <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (fail_now) health_fail <= 1'b1;
      if (push_req && !health_fail && !fail_now && full && !pop) overflow <= 1'b1;
      if (fail_now) begin
        wptr <= '0;
        rptr <= '0;
        fill <= '0;
      end else begin
        if (push_ok) begin
          mem[wptr] <= sr_next;
          wptr      <= wptr + AW'(1);
        end
        if (pop) rptr <= rptr + AW'(1);
        fill <= fill + (AW+1)'(push_ok) - (AW+1)'(pop);
      end
    end
  end

  assign rd_data = mem[rptr];

endmodule

// File: tb/tb_rng_byte_reader.sv
// Directed bench for rng_byte_reader: raw bits are driven as d_in bytes of known parity,
// one bit per SAMPLE_DIV window, and outputs are sampled on the falling edge.
module tb_rng_byte_reader;
  logic       clk = 1'b0;
  logic       rst, en, rd_ready;
  logic [7:0] d_in;
  logic [7:0] rd_data;
  logic       rd_valid, overflow, health_fail;
  logic [2:0] fill;

  int vectors = 0;
  int errors  = 0;

  rng_byte_reader #(.SAMPLE_DIV(4), .DEPTH(4), .REP_LIMIT(32)) dut (
    .clk(clk), .rst(rst), .en(en), .d_in(d_in),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .fill(fill), .overflow(overflow), .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  // 8'hB5 has odd parity (raw 1), 8'h3C even parity (raw 0).
  task automatic send_bit(input logic b);
    d_in = b ? 8'hB5 : 8'h3C;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin send_bit(1'b1); send_bit(1'b0); end
      else      begin send_bit(1'b0); send_bit(1'b1); end
    end
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic restart();
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
  endtask

  task automatic do_reset();
    en = 1'b0; rd_ready = 1'b0; d_in = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [7:0] byte_val(input int i);
    return 8'(i * 29 + 8'h13);
  endfunction

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({rd_valid, fill, overflow, health_fail, rd_data} !== 13'h0) begin
      errors++;
      $display("FAIL reset_idle: got valid=%b fill=%0d ovf=%b hf=%b data=%h, want all 0",
               rd_valid, fill, overflow, health_fail, rd_data);
    end
    en = 1'b1;
    send_byte(8'h12);
    send_byte(8'h34);
    settle();
    vectors++;
    if (fill !== 3'd2) begin errors++; $display("FAIL reset_prefill: fill=%0d want 2", fill); end
    rst = 1'b1;
    #1;
    vectors++;
    if ({rd_valid, fill, overflow, health_fail, rd_data} !== 13'h0) begin
      errors++;
      $display("FAIL reset_midrun: got valid=%b fill=%0d ovf=%b hf=%b data=%h, want all 0",
               rd_valid, fill, overflow, health_fail, rd_data);
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin send_bit(1'b1); send_bit(1'b0); end
    settle();
    vectors++;
    if (rd_valid !== 1'b1 || fill !== 3'd1 || rd_data !== 8'hFF) begin
      errors++;
      $display("FAIL basic_ff: valid=%b fill=%0d data=%h want 1/1/ff", rd_valid, fill, rd_data);
    end
    restart();
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    end
    settle();
    vectors++;
    if (fill !== 3'd2) begin errors++; $display("FAIL basic_fill2: fill=%0d want 2", fill); end
    en = 1'b0;
    vectors++;
    if (rd_data !== 8'hFF) begin errors++; $display("FAIL basic_rd0: data=%h want ff", rd_data); end
    rd_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (rd_data !== 8'hAA || rd_valid !== 1'b1) begin
      errors++; $display("FAIL basic_rd1: data=%h valid=%b want aa/1", rd_data, rd_valid);
    end
    @(negedge clk);
    rd_ready = 1'b0;
    vectors++;
    if (fill !== 3'd0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL basic_empty: fill=%0d valid=%b want 0/0", fill, rd_valid);
    end
  endtask

  task automatic test_health();
    do_reset();
    en = 1'b1;
    send_byte(8'hC2);
    for (int i = 0; i < 31; i++) send_bit(1'b0);
    d_in = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (health_fail !== 1'b0 || fill !== 3'd1 || rd_valid !== 1'b1 || rd_data !== 8'hC2) begin
      errors++;
      $display("FAIL health_pre: hf=%b fill=%0d valid=%b data=%h want 0/1/1/c2",
               health_fail, fill, rd_valid, rd_data);
    end
    repeat (3) @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (health_fail !== 1'b1 || fill !== 3'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL health_trip: hf=%b fill=%0d valid=%b want 1/0/0", health_fail, fill, rd_valid);
    end
    restart();
    send_byte(8'hAA);
    send_byte(8'h55);
    settle();
    vectors++;
    if (health_fail !== 1'b1 || fill !== 3'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL health_hold: hf=%b fill=%0d valid=%b want 1/0/0", health_fail, fill, rd_valid);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 4; i++) send_byte(8'(i * 8'h11));
    settle();
    vectors++;
    if (fill !== 3'd4 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_full: fill=%0d ovf=%b want 4/0", fill, overflow);
    end
    restart();
    send_byte(8'h55);
    settle();
    vectors++;
    if (fill !== 3'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_drop: fill=%0d ovf=%b want 4/1", fill, overflow);
    end
    en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i * 8'h11);
      vectors++;
      if (rd_data !== exp || rd_valid !== 1'b1) begin
        errors++; $display("FAIL ovf_read%0d: data=%h valid=%b want %h/1", i, rd_data, rd_valid, exp);
      end
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
    end
    vectors++;
    if (fill !== 3'd0) begin errors++; $display("FAIL ovf_drain: fill=%0d want 0", fill); end

    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 5; i++) send_byte(8'hA0 + 8'(i));
    rd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_ready = 1'b0;
    en = 1'b0;
    vectors++;
    if (overflow !== 1'b0 || fill !== 3'd4) begin
      errors++; $display("FAIL ovf_pushpop: ovf=%b fill=%0d want 0/4", overflow, fill);
    end
    for (int i = 2; i <= 5; i++) begin
      exp = 8'hA0 + 8'(i);
      vectors++;
      if (rd_data !== exp) begin
        errors++; $display("FAIL ovf_pp_read%0d: data=%h want %h", i, rd_data, exp);
      end
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
    end
  endtask

  task automatic test_en_drop();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin send_bit(1'b1); send_bit(1'b0); end
    settle();
    restart();
    send_byte(8'h5A);
    settle();
    vectors++;
    if (fill !== 3'd1 || rd_data !== 8'h5A) begin
      errors++; $display("FAIL en_drop: fill=%0d data=%h want 1/5a", fill, rd_data);
    end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    do_reset();
    en = 1'b1;
    fork
      begin
        for (int i = 0; i < 14; i++) send_byte(byte_val(i));
        settle();
        en = 1'b0;
      end
      begin
        logic [7:0] exp;
        repeat (14 * 64 + 40) begin
          @(negedge clk);
          rd_ready = ($urandom_range(0, 3) != 0);
          if (rd_valid && rd_ready) begin
            exp = byte_val(got);
            vectors++;
            if (rd_data !== exp) begin
              errors++; $display("FAIL b2b_byte%0d: data=%h want %h", got, rd_data, exp);
            end
            got++;
          end
        end
        rd_ready = 1'b0;
      end
    join
    vectors++;
    if (got != 14 || overflow !== 1'b0) begin
      errors++; $display("FAIL b2b_count: popped=%0d ovf=%b want 14/0", got, overflow);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rd_ready = 1'b0; d_in = 8'h00;
    test_reset();
    test_basic();
    test_health();
    test_overflow();
    test_en_drop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
